// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: two-flop sync, tick-sampled debounce,
// press/release pulses, long-press hold flag and optional auto-repeat.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RELEASED | debounced level low, waiting for a press
// ST_PRESSED  | level high, hold counter running towards HOLD_TICKS
// ST_HELD     | long press; hold=1, repeat counter active while repeat_en
module button_conditioner #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int HOLD_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic                tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] hold
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    localparam logic [PW-1:0] DIV_LAST    = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] DIV_PRE     = PW'(TICK_DIV - 2);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    logic [PW-1:0]       div_q;
    logic [CHANNELS-1:0] s1_q;
    logic [CHANNELS-1:0] s_q;

    // tick is registered one cycle early so it is high exactly while div_q == TICK_DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            tick  <= (div_q == DIV_PRE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s_q  <= '0;
        end else begin
            s1_q <= btn_in;
            s_q  <= s1_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [SW-1:0] stab_q, stab_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          hold_q, hold_d;
        logic          rise, fall;

        always_comb begin
            state_d = state_q;
            stab_d  = stab_q;
            hcnt_d  = hcnt_q;
            rcnt_d  = rcnt_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            hold_d  = hold_q;
            rise    = 1'b0;
            fall    = 1'b0;

            if (tick) begin
                if (s_q[i] == level_q) begin
                    stab_d = '0;
                end else if (stab_q == STABLE_LAST) begin
                    level_d = s_q[i];
                    stab_d  = '0;
                    rise    = s_q[i];
                    fall    = ~s_q[i];
                end else begin
                    stab_d = stab_q + 1'b1;
                end

                case (state_q)
                    ST_RELEASED: begin
                        if (rise) begin
                            state_d = ST_PRESSED;
                            press_d = 1'b1;
                            hcnt_d  = '0;
                            rcnt_d  = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (fall) begin
                            state_d = ST_RELEASED;
                            rel_d   = 1'b1;
                            hold_d  = 1'b0;
                        end else if (hcnt_q == HOLD_LAST) begin
                            state_d = ST_HELD;
                            hcnt_d  = HOLD_MAX;
                            hold_d  = 1'b1;
                        end else begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        // a release landing on a repeat tick suppresses that repeat
                        if (fall) begin
                            state_d = ST_RELEASED;
                            rel_d   = 1'b1;
                            hold_d  = 1'b0;
                            rcnt_d  = '0;
                        end else if (!repeat_en[i]) begin
                            rcnt_d = '0;
                        end else if (rcnt_q == REPEAT_LAST) begin
                            press_d = 1'b1;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_RELEASED;
                        hold_d  = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_RELEASED;
                stab_q  <= '0;
                hcnt_q  <= '0;
                rcnt_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                hold_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                stab_q  <= stab_d;
                hcnt_q  <= hcnt_d;
                rcnt_q  <= rcnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                hold_q  <= hold_d;
            end
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
        assign hold[i]          = hold_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset/prescaler, clean press, bounce,
// hold with auto-repeat, release on a repeat tick, and reset with buttons held.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_in = 2'b00;
    logic [1:0] repeat_en = 2'b00;
    logic       tick;
    logic [1:0] level, press, release_pulse, hold;

    int n_assert = 0;
    int n_fail   = 0;

    button_conditioner #(
        .CHANNELS    (2),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .HOLD_TICKS  (8),
        .REPEAT_TICKS(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .repeat_en    (repeat_en),
        .tick         (tick),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .hold         (hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] e_level, input logic [1:0] e_press,
                        input logic [1:0] e_rel, input logic [1:0] e_hold);
        check({tag, ".level"},   32'(level),         32'(e_level));
        check({tag, ".press"},   32'(press),         32'(e_press));
        check({tag, ".release"}, 32'(release_pulse), 32'(e_rel));
        check({tag, ".hold"},    32'(hold),          32'(e_hold));
    endtask

    // Advance to the negedge inside the next tick cycle, bounded.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (tick === 1'b1) found = 1'b1;
        end
        check("tick_wait", 32'(found), 32'd1);
    endtask

    int bnc [6] = '{1, 1, 0, 1, 1, 1};

    initial begin
        // reset and prescaler
        repeat (3) begin
            @(negedge clk);
            outs("reset", 2'b00, 2'b00, 2'b00, 2'b00);
            check("reset.tick", 32'(tick), 32'd0);
        end
        rst = 1'b0;
        check("tick_c0", 32'(tick), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("tick_cycle", 32'(tick), 32'((k % 4) == 3));
        end

        // clean press and release on channel 0
        wait_tick();
        btn_in = 2'b01;
        wait_tick();
        wait_tick();
        wait_tick();
        outs("pre_press", 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        outs("press", 2'b01, 2'b01, 2'b00, 2'b00);
        @(negedge clk);
        outs("press_end", 2'b01, 2'b00, 2'b00, 2'b00);
        wait_tick();
        btn_in = 2'b00;
        wait_tick();
        wait_tick();
        wait_tick();
        outs("pre_rel", 2'b01, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        outs("release", 2'b00, 2'b00, 2'b01, 2'b00);
        @(negedge clk);
        outs("release_end", 2'b00, 2'b00, 2'b00, 2'b00);

        // bounce 1,1,0,1,1,1: single press on the 6th tick
        wait_tick();
        for (int i = 0; i < 6; i++) begin
            btn_in = {1'b0, bnc[i] != 0};
            wait_tick();
            @(negedge clk);
            outs("bounce", {1'b0, i == 5}, {1'b0, i == 5}, 2'b00, 2'b00);
        end
        wait_tick();
        btn_in = 2'b00;
        wait_tick();
        wait_tick();
        wait_tick();
        @(negedge clk);
        outs("bounce_rel", 2'b00, 2'b00, 2'b01, 2'b00);

        // long press with auto-repeat, then repeat disabled
        wait_tick();
        repeat_en = 2'b01;
        btn_in    = 2'b01;
        wait_tick();
        wait_tick();
        wait_tick();
        @(negedge clk);
        outs("lp_press", 2'b01, 2'b01, 2'b00, 2'b00);
        for (int k = 1; k <= 18; k++) begin
            wait_tick();
            @(negedge clk);
            outs("lp", 2'b01, {1'b0, (k == 10) || (k == 12) || (k == 14)}, 2'b00, {1'b0, k >= 8});
            if (k == 10) begin
                @(negedge clk);
                outs("lp_pulse_end", 2'b01, 2'b00, 2'b00, 2'b01);
            end
            if (k == 14) repeat_en = 2'b00;
        end

        // re-enable repeat; release lands on the second repeat tick
        repeat_en = 2'b01;
        wait_tick();
        @(negedge clk);
        outs("re_t1", 2'b01, 2'b00, 2'b00, 2'b01);
        btn_in = 2'b00;
        wait_tick();
        @(negedge clk);
        outs("re_t2", 2'b01, 2'b01, 2'b00, 2'b01);
        wait_tick();
        @(negedge clk);
        outs("re_t3", 2'b01, 2'b00, 2'b00, 2'b01);
        wait_tick();
        @(negedge clk);
        outs("rel_on_rep", 2'b00, 2'b00, 2'b01, 2'b00);

        // both channels one tick apart, then reset mid-hold
        repeat_en = 2'b00;
        wait_tick();
        btn_in = 2'b01;
        wait_tick();
        btn_in = 2'b11;
        wait_tick();
        wait_tick();
        @(negedge clk);
        outs("dual_p0", 2'b01, 2'b01, 2'b00, 2'b00);
        wait_tick();
        @(negedge clk);
        outs("dual_p1", 2'b11, 2'b10, 2'b00, 2'b00);
        for (int k = 5; k <= 12; k++) begin
            wait_tick();
            @(negedge clk);
            outs("dual_hold", 2'b11, 2'b00, 2'b00, {k >= 12, k >= 11});
        end
        rst = 1'b1;
        @(negedge clk);
        outs("mid_rst", 2'b00, 2'b00, 2'b00, 2'b00);
        check("mid_rst.tick", 32'(tick), 32'd0);
        @(negedge clk);
        outs("mid_rst2", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("post_rst_tick", 32'(tick), 32'(k == 3));
        end
        wait_tick();
        wait_tick();
        outs("post_rst_pre", 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk);
        outs("post_rst_press", 2'b11, 2'b11, 2'b00, 2'b00);
        @(negedge clk);
        outs("post_rst_end", 2'b11, 2'b00, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
